// File: rtl/frame_pkg.sv
// Shared types for the call-frame manager: saved-frame record, FSM states and error codes.
package frame_pkg;

    localparam int PKG_LVA_AW = 8;
    localparam int PKG_PC_W   = 16;

    typedef struct packed {
        logic [PKG_PC_W-1:0]   pc;
        logic [PKG_LVA_AW-1:0] base;
        logic [PKG_LVA_AW-1:0] nlocals;
    } frame_t;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_INV_POP     = 3'd1,
        S_INV_WR      = 3'd2,
        S_INV_COMMIT  = 3'd3,
        S_RET_POP     = 3'd4,
        S_RET_RESTORE = 3'd5,
        S_RET_PUSH    = 3'd6,
        S_FIN         = 3'd7
    } fstate_e;

    typedef enum logic [1:0] {
        ERR_OK  = 2'b00,
        ERR_OVF = 2'b01,
        ERR_UNF = 2'b10,
        ERR_ILL = 2'b11
    } err_e;

endpackage

// File: rtl/frame_mem.sv
// Saved-frame store: one write port, one synchronous read port (data one cycle after address).
module frame_mem
    import frame_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  frame_t                   wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output frame_t                   rdata
);

    frame_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/frame_ctrl.sv
// Invoke/return sequencer: moves arguments from the eval stack into a fresh LVA window and
// saves/restores caller frames in frame_mem.
module frame_ctrl
    import frame_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int LVA_AW    = PKG_LVA_AW,
    parameter int PC_W      = PKG_PC_W,
    parameter int MAX_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         invoke,
    input  logic                         ret,
    input  logic                         ret_val,
    input  logic [LVA_AW-1:0]            nargs,
    input  logic [LVA_AW-1:0]            nlocals,
    input  logic [PC_W-1:0]              target_pc,
    input  logic [PC_W-1:0]              return_pc,
    output logic [PC_W-1:0]              pc_out,
    output logic                         pc_load,
    output logic                         done,
    output logic                         busy,
    output logic [1:0]                   err,
    output logic [LVA_AW-1:0]            lva_base,
    output logic [$clog2(MAX_DEPTH):0]   depth,
    output logic                         evalpush,
    output logic                         evaltrigger,
    output logic [DATA_W-1:0]            evalwrite,
    input  logic [DATA_W-1:0]            evalread,
    input  logic                         evaldone,
    output logic                         lvaop,
    output logic                         lvatrigger,
    output logic [LVA_AW-1:0]            lvaindex,
    output logic [DATA_W-1:0]            lvawrite,
    input  logic [DATA_W-1:0]            lvaread,
    input  logic                         lvadone,
    output logic [2:0]                   dbg_state
);

    localparam int                DW         = $clog2(MAX_DEPTH);
    localparam logic [DW:0]       DEPTH_FULL = (DW+1)'(MAX_DEPTH);
    localparam logic [LVA_AW+1:0] LVA_SIZE   = (LVA_AW+2)'(1) << LVA_AW;

    fstate_e             state, state_n;
    logic                fired, fired_n;
    err_e                err_q;
    logic [PC_W-1:0]     pc_q, tpc_q, rpc_q;
    logic [LVA_AW-1:0]   cur_nlocals, new_base, nargs_q, nlocals_q, k_q;
    logic [DATA_W-1:0]   data_q;
    logic                rv_q;
    logic [LVA_AW+1:0]   base_sum, win_end;
    logic                inv_ill, inv_ovf, mem_we;
    frame_t              wr_frame, rd_frame;
    logic                unused_lvaread;

    assign unused_lvaread = ^lvaread;

    assign base_sum = (depth == '0) ? '0 : ({2'b00, lva_base} + {2'b00, cur_nlocals});
    assign win_end  = base_sum + {2'b00, nlocals};
    assign inv_ill  = nargs > nlocals;
    assign inv_ovf  = (depth == DEPTH_FULL) || (win_end > LVA_SIZE);

    assign wr_frame = '{pc: rpc_q, base: lva_base, nlocals: cur_nlocals};

    // Read address tracks the top saved frame, so the IDLE cycle of a return already fetches it.
    frame_mem #(.DEPTH(MAX_DEPTH)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (depth[DW-1:0]),
        .wdata (wr_frame),
        .raddr (DW'(depth - 1'b1)),
        .rdata (rd_frame)
    );

    assign pc_out    = pc_q;
    assign err       = err_q;
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // Port handshake: a request is a one-cycle trigger; the port answers with a one-cycle done,
    // which is accepted only once the trigger for the current state has been issued (fired).
    always_comb begin
        state_n     = state;
        evaltrigger = 1'b0;
        evalpush    = 1'b0;
        evalwrite   = '0;
        lvatrigger  = 1'b0;
        lvaop       = 1'b0;
        lvaindex    = '0;
        lvawrite    = '0;
        done        = 1'b0;
        pc_load     = 1'b0;
        mem_we      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (invoke && ret) begin
                    state_n = S_FIN;
                end else if (invoke) begin
                    if (inv_ill || inv_ovf)  state_n = S_FIN;
                    else if (nargs == '0)    state_n = S_INV_COMMIT;
                    else                     state_n = S_INV_POP;
                end else if (ret) begin
                    if (depth == '0)         state_n = S_FIN;
                    else if (ret_val)        state_n = S_RET_POP;
                    else                     state_n = S_RET_RESTORE;
                end
            end
            S_INV_POP: begin
                evaltrigger = !fired;
                if (fired && evaldone) state_n = S_INV_WR;
            end
            S_INV_WR: begin
                lvaop      = 1'b1;
                lvaindex   = new_base + nargs_q - LVA_AW'(1) - k_q;
                lvawrite   = data_q;
                lvatrigger = !fired;
                if (fired && lvadone) begin
                    state_n = (k_q == nargs_q - LVA_AW'(1)) ? S_INV_COMMIT : S_INV_POP;
                end
            end
            S_INV_COMMIT: begin
                mem_we  = 1'b1;
                state_n = S_FIN;
            end
            S_RET_POP: begin
                evaltrigger = !fired;
                if (fired && evaldone) state_n = S_RET_RESTORE;
            end
            S_RET_RESTORE: begin
                state_n = rv_q ? S_RET_PUSH : S_FIN;
            end
            S_RET_PUSH: begin
                evalpush    = 1'b1;
                evalwrite   = data_q;
                evaltrigger = !fired;
                if (fired && evaldone) state_n = S_FIN;
            end
            S_FIN: begin
                done    = 1'b1;
                pc_load = (err_q == ERR_OK);
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        fired_n = (state_n == state) ? (fired | evaltrigger | lvatrigger) : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            fired       <= 1'b0;
            err_q       <= ERR_OK;
            pc_q        <= '0;
            tpc_q       <= '0;
            rpc_q       <= '0;
            lva_base    <= '0;
            cur_nlocals <= '0;
            new_base    <= '0;
            nargs_q     <= '0;
            nlocals_q   <= '0;
            k_q         <= '0;
            data_q      <= '0;
            rv_q        <= 1'b0;
            depth       <= '0;
        end else begin
            state <= state_n;
            fired <= fired_n;
            unique case (state)
                S_IDLE: begin
                    if (invoke && ret) begin
                        err_q <= ERR_ILL;
                    end else if (invoke) begin
                        nargs_q   <= nargs;
                        nlocals_q <= nlocals;
                        tpc_q     <= target_pc;
                        rpc_q     <= return_pc;
                        new_base  <= base_sum[LVA_AW-1:0];
                        k_q       <= '0;
                        if (inv_ill)      err_q <= ERR_ILL;
                        else if (inv_ovf) err_q <= ERR_OVF;
                        else              err_q <= ERR_OK;
                    end else if (ret) begin
                        rv_q  <= ret_val;
                        err_q <= (depth == '0) ? ERR_UNF : ERR_OK;
                    end
                end
                S_INV_POP: if (fired && evaldone) data_q <= evalread;
                S_INV_WR:  if (fired && lvadone) k_q <= k_q + LVA_AW'(1);
                S_INV_COMMIT: begin
                    depth       <= depth + 1'b1;
                    lva_base    <= new_base;
                    cur_nlocals <= nlocals_q;
                    pc_q        <= tpc_q;
                end
                S_RET_POP: if (fired && evaldone) data_q <= evalread;
                S_RET_RESTORE: begin
                    lva_base    <= rd_frame.base;
                    cur_nlocals <= rd_frame.nlocals;
                    pc_q        <= rd_frame.pc;
                    depth       <= depth - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_ctrl.sv
// Bench for frame_ctrl: behavioural eval stack and LVA responders plus a frame-level reference model.
module tb_frame_ctrl;

    logic        clk, rst;
    logic        invoke, ret, ret_val;
    logic [7:0]  nargs, nlocals;
    logic [15:0] target_pc, return_pc, pc_out;
    logic        pc_load, done, busy;
    logic [1:0]  err;
    logic [7:0]  lva_base;
    logic [4:0]  depth;
    logic        evalpush, evaltrigger, evaldone;
    logic [31:0] evalwrite, evalread;
    logic        lvaop, lvatrigger, lvadone;
    logic [7:0]  lvaindex;
    logic [31:0] lvawrite, lvaread;
    logic [2:0]  dbg_state;

    frame_ctrl dut (
        .clk(clk), .rst(rst), .invoke(invoke), .ret(ret), .ret_val(ret_val),
        .nargs(nargs), .nlocals(nlocals), .target_pc(target_pc), .return_pc(return_pc),
        .pc_out(pc_out), .pc_load(pc_load), .done(done), .busy(busy), .err(err),
        .lva_base(lva_base), .depth(depth),
        .evalpush(evalpush), .evaltrigger(evaltrigger), .evalwrite(evalwrite),
        .evalread(evalread), .evaldone(evaldone),
        .lvaop(lvaop), .lvatrigger(lvatrigger), .lvaindex(lvaindex),
        .lvawrite(lvawrite), .lvaread(lvaread), .lvadone(lvadone),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- responders (the "devices") ----------------
    logic [31:0] stk[$];
    logic [31:0] lva_dev [256];
    int          ev_wait, lv_wait;
    bit          ev_busy, lv_busy, ev_push_q, lv_op_q;
    logic [31:0] ev_wd, lv_wd;
    logic [7:0]  lv_idx;

    always @(negedge clk) begin
        evaldone = 1'b0;
        if (rst) begin
            ev_busy = 1'b0;
        end else if (ev_busy) begin
            if (ev_wait == 0) begin
                if (ev_push_q) stk.push_back(ev_wd);
                else if (stk.size() > 0) evalread = stk.pop_back();
                else evalread = '0;
                evaldone = 1'b1;
                ev_busy  = 1'b0;
            end else begin
                ev_wait--;
            end
        end else if (evaltrigger) begin
            ev_busy   = 1'b1;
            ev_wait   = $urandom_range(0, 2);
            ev_push_q = evalpush;
            ev_wd     = evalwrite;
        end
    end

    always @(negedge clk) begin
        lvadone = 1'b0;
        if (rst) begin
            lv_busy = 1'b0;
        end else if (lv_busy) begin
            if (lv_wait == 0) begin
                if (lv_op_q) lva_dev[lv_idx] = lv_wd;
                lvaread = lva_dev[lv_idx];
                lvadone = 1'b1;
                lv_busy = 1'b0;
            end else begin
                lv_wait--;
            end
        end else if (lvatrigger) begin
            lv_busy = 1'b1;
            lv_wait = $urandom_range(0, 2);
            lv_op_q = lvaop;
            lv_idx  = lvaindex;
            lv_wd   = lvawrite;
        end
    end

    // ---------------- traffic monitor ----------------
    int ev_cnt = 0, lv_cnt = 0, ovl_cnt = 0, done_cnt = 0;
    always @(negedge clk) begin
        if (evaltrigger) ev_cnt++;
        if (lvatrigger) lv_cnt++;
        if (evaltrigger && lvatrigger) ovl_cnt++;
        if (done) done_cnt++;
    end

    // ---------------- reference model ----------------
    typedef struct { int pc; int base; int nl; } mframe_t;
    logic [31:0] exp_q[$];
    logic [31:0] m_lva [256];
    mframe_t     m_frames[$];
    int          m_base = 0, m_cur = 0;

    task automatic push_val(input logic [31:0] v);
        stk.push_back(v);
        exp_q.push_back(v);
    endtask

    task automatic cmd(input bit inv, input bit rt, input bit rv, input int na, input int nl,
                       input int tpc, input int rpc, input string name);
        int exp_err, exp_pc, exp_ev, exp_lv, exp_lat, nb, n, ev0, lv0, ov0, bad;
        bit exp_load;
        logic [31:0] v;
        mframe_t f;
        exp_err = 0; exp_pc = 0; exp_ev = 0; exp_lv = 0; exp_lat = -1; exp_load = 0; v = '0;
        if (inv && rt) begin
            exp_err = 3; exp_lat = 1;
        end else if (inv) begin
            nb = (m_frames.size() == 0) ? 0 : m_base + m_cur;
            if (na > nl) begin
                exp_err = 3; exp_lat = 1;
            end else if (m_frames.size() == 16 || nb + nl > 256) begin
                exp_err = 1; exp_lat = 1;
            end else begin
                for (int i = 0; i < na; i++) m_lva[nb + i] = exp_q[exp_q.size() - na + i];
                for (int i = 0; i < na; i++) void'(exp_q.pop_back());
                m_frames.push_back('{pc: rpc, base: m_base, nl: m_cur});
                m_base = nb; m_cur = nl;
                exp_pc = tpc; exp_ev = na; exp_lv = na; exp_load = 1;
                if (na == 0) exp_lat = 2;
            end
        end else begin
            if (m_frames.size() == 0) begin
                exp_err = 2; exp_lat = 1;
            end else begin
                if (rv) v = exp_q.pop_back();
                f = m_frames.pop_back();
                m_base = f.base; m_cur = f.nl;
                exp_pc = f.pc; exp_load = 1;
                if (rv) begin exp_q.push_back(v); exp_ev = 2; end
                else exp_lat = 2;
            end
        end

        @(negedge clk);
        ev0 = ev_cnt; lv0 = lv_cnt; ov0 = ovl_cnt;
        invoke = inv; ret = rt; ret_val = rv;
        nargs = 8'(na); nlocals = 8'(nl); target_pc = 16'(tpc); return_pc = 16'(rpc);
        @(negedge clk);
        invoke = 0; ret = 0; ret_val = 0;
        n = 1;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: no done after %0d cycles, required done", name, n);
        end
        if (exp_lat >= 0) begin
            checks++;
            if (n !== exp_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, exp_lat);
            end
        end
        checks++;
        if (err !== 2'(exp_err)) begin
            errors++;
            $display("FAIL %s err: got %0d, expected %0d", name, err, exp_err);
        end
        checks++;
        if (pc_load !== exp_load) begin
            errors++;
            $display("FAIL %s pc_load: got %b, expected %b", name, pc_load, exp_load);
        end
        if (exp_load) begin
            checks++;
            if (pc_out !== 16'(exp_pc)) begin
                errors++;
                $display("FAIL %s pc_out: got %h, expected %h", name, pc_out, 16'(exp_pc));
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || err !== 2'(exp_err)) begin
            errors++;
            $display("FAIL %s after-done: done=%b busy=%b err=%0d, expected 0 0 %0d",
                     name, done, busy, err, exp_err);
        end
        checks++;
        if (depth !== 5'(m_frames.size()) || lva_base !== 8'(m_base)) begin
            errors++;
            $display("FAIL %s frame: depth=%0d lva_base=%0d, expected %0d %0d",
                     name, depth, lva_base, m_frames.size(), 8'(m_base));
        end
        checks++;
        if (ev_cnt - ev0 != exp_ev || lv_cnt - lv0 != exp_lv || ovl_cnt != ov0) begin
            errors++;
            $display("FAIL %s traffic: eval=%0d lva=%0d overlap=%0d, expected %0d %0d 0",
                     name, ev_cnt - ev0, lv_cnt - lv0, ovl_cnt - ov0, exp_ev, exp_lv);
        end
        bad = (stk.size() != exp_q.size()) ? 1 : 0;
        if (bad == 0) for (int i = 0; i < stk.size(); i++) if (stk[i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s stack: size=%0d bad=%0d, expected size=%0d bad=0",
                     name, stk.size(), bad, exp_q.size());
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (lva_dev[i] !== m_lva[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s lva: %0d words differ, expected 0", name, bad);
        end
    endtask

    task automatic unwind();
        while (m_frames.size() > 0) cmd(0, 1, 0, 0, 0, 0, 0, "unwind");
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 0 || done !== 0 || pc_load !== 0 || err !== 0 || pc_out !== 0) begin
            errors++;
            $display("FAIL reset_ctl: busy=%b done=%b pc_load=%b err=%0d pc_out=%h, expected all 0",
                     busy, done, pc_load, err, pc_out);
        end
        checks++;
        if (depth !== 0 || lva_base !== 0 || evaltrigger !== 0 || lvatrigger !== 0) begin
            errors++;
            $display("FAIL reset_frame: depth=%0d lva_base=%0d etrig=%b ltrig=%b, expected 0",
                     depth, lva_base, evaltrigger, lvatrigger);
        end
    endtask

    task automatic test_invoke_basic();
        push_val(11); push_val(22); push_val(33);
        cmd(1, 0, 0, 3, 5, 'h40, 'h10, "invoke3");
        checks++;
        if (lva_dev[0] !== 11 || lva_dev[1] !== 22 || lva_dev[2] !== 33) begin
            errors++;
            $display("FAIL invoke3_args: lva[0..2]=%0d,%0d,%0d expected 11,22,33",
                     lva_dev[0], lva_dev[1], lva_dev[2]);
        end
    endtask

    task automatic test_nested();
        push_val(99);
        cmd(1, 0, 0, 1, 2, 'h80, 'h20, "nested");
        checks++;
        if (lva_dev[5] !== 99 || lva_base !== 5 || depth !== 2) begin
            errors++;
            $display("FAIL nested_frame: lva[5]=%0d base=%0d depth=%0d expected 99 5 2",
                     lva_dev[5], lva_base, depth);
        end
    endtask

    task automatic test_return();
        push_val(77);
        cmd(0, 1, 1, 0, 0, 0, 0, "ret_val");
        checks++;
        if (stk.size() == 0 || stk[stk.size()-1] !== 77 || pc_out !== 16'h20) begin
            errors++;
            $display("FAIL ret_val_top: top=%0d pc_out=%h expected 77 0020",
                     (stk.size() > 0) ? stk[stk.size()-1] : 0, pc_out);
        end
        cmd(0, 1, 0, 0, 0, 0, 0, "ret_plain");
    endtask

    task automatic test_errors();
        cmd(0, 1, 0, 0, 0, 0, 0, "underflow");
        push_val(5);
        cmd(1, 1, 0, 1, 2, 'h50, 'h60, "illegal_both");
        cmd(1, 0, 0, 2, 1, 'h50, 'h60, "illegal_nargs");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) cmd(1, 0, 0, 0, 1, 'h100 + i, 'h200 + i, "depth_ovf");
        unwind();
        cmd(1, 0, 0, 0, 200, 'h300, 'h301, "win_big");
        cmd(1, 0, 0, 0, 100, 'h302, 'h303, "win_ovf");
        cmd(1, 0, 0, 0, 56, 'h304, 'h305, "win_exact");
        unwind();
    endtask

    task automatic test_random();
        int r, na, nl;
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                na = $urandom_range(0, 3);
                nl = $urandom_range(0, na + 3);
                for (int i = 0; i < na; i++) push_val($urandom);
                cmd(1, 0, 0, na, nl, $urandom_range(0, 65535), $urandom_range(0, 65535), "rand_inv");
            end else if (r <= 7) begin
                cmd(0, 1, 0, 0, 0, 0, 0, "rand_ret");
            end else begin
                push_val($urandom);
                cmd(0, 1, 1, 0, 0, 0, 0, "rand_retv");
            end
        end
        unwind();
    endtask

    task automatic test_reset_mid();
        int n, d0;
        cmd(1, 0, 0, 0, 2, 'h11, 'h12, "pre_reset");
        push_val(1); push_val(2); push_val(3);
        @(negedge clk);
        invoke = 1; nargs = 3; nlocals = 3; target_pc = 'h70; return_pc = 'h71;
        @(negedge clk);
        invoke = 0;
        n = 0;
        while (!lvatrigger && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!lvatrigger) begin
            errors++;
            $display("FAIL reset_mid_wr: lvatrigger never seen, required 1");
        end
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 0 || depth !== 0 || lva_base !== 0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b depth=%0d lva_base=%0d expected 0 0 0",
                     busy, depth, lva_base);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt != d0 || evaltrigger !== 0 || lvatrigger !== 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: done pulses=%0d etrig=%b ltrig=%b expected 0 0 0",
                     done_cnt - d0, evaltrigger, lvatrigger);
        end
    endtask

    initial begin
        invoke = 0; ret = 0; ret_val = 0; nargs = 0; nlocals = 0;
        target_pc = 0; return_pc = 0; evaldone = 0; lvadone = 0;
        evalread = 0; lvaread = 0; rst = 1;
        for (int i = 0; i < 256; i++) begin
            lva_dev[i] = '0;
            m_lva[i]   = '0;
        end
        test_reset();
        test_invoke_basic();
        test_nested();
        test_return();
        unwind();
        test_errors();
        test_overflow();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
